// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART pad arbiter.
// State encoding, idle line level, bit-time and counter width helpers.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    LOADER          = 2'd0,
    DRAIN_TO_CORE   = 2'd1,
    CORE            = 2'd2,
    DRAIN_TO_LOADER = 2'd3
  } arb_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int bit_cycles(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/uart_idle_detect.sv
// Line-idle run counter and drain timeout counter.
// Ports: clk, rst_n, clear, active, line_idle in; done, timeout out.
module uart_idle_detect
  import uart_arb_pkg::*;
#(
  parameter int IDLE_CYCLES = 120,
  parameter int TO_CYCLES   = 320
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic line_idle,
  output logic done,
  output logic timeout
);

  localparam int IW = cnt_width(IDLE_CYCLES);
  localparam int TW = cnt_width(TO_CYCLES);

  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

  logic [IW-1:0] idle_cnt;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear) begin
      idle_cnt <= '0;
    end else if (active) begin
      if (!line_idle) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (clear) begin
      to_cnt <= '0;
    end else if (active && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Counts hold cycles already seen, so the limit is hit on the
  // cycle that would make the count reach the full length.
  assign done    = active && line_idle &&
                   (idle_cnt == IDLE_LAST);
  assign timeout = active && (to_cnt == TO_LAST);

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares the UART pads between the boot loader and the core UART.
// Ports: pads, loader/core RX+TX, fetch enable, owner/status flags.
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int CLK_FREQ_HZ        = 50000000,
  parameter int BAUD               = 115200,
  parameter int IDLE_BITS          = 12,
  parameter int DRAIN_TIMEOUT_BITS = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_req_i,
  input  logic uart_rx_i,
  output logic uart_tx_o,
  output logic loader_rxd_o,
  input  logic loader_txd_i,
  output logic core_rx_o,
  input  logic core_tx_i,
  output logic fetch_enable_o,
  output logic owner_o,
  output logic switching_o,
  output logic forced_switch_o
);

  localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ_HZ, BAUD);
  localparam int IDLE_CYCLES = IDLE_BITS * BIT_CYCLES;
  localparam int TO_CYCLES   = DRAIN_TIMEOUT_BITS * BIT_CYCLES;

  generate
    if (BIT_CYCLES < 4) begin : g_bad_baud
      $error("uart_port_arbiter: BIT_CYCLES below 4");
    end
  endgenerate

  logic sel_meta;
  logic sel_sync;
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
      rx_meta  <= IDLE_LEVEL;
      rx_sync  <= IDLE_LEVEL;
    end else begin
      sel_meta <= sel_req_i;
      sel_sync <= sel_meta;
      rx_meta  <= uart_rx_i;
      rx_sync  <= rx_meta;
    end
  end

  arb_state_t state;
  arb_state_t state_next;
  logic       forced_next;
  logic       drain;
  logic       old_tx;
  logic       line_idle;
  logic       cnt_clear;
  logic       idle_done;
  logic       drain_to;
  logic       core_side;

  assign drain = (state == DRAIN_TO_CORE) ||
                 (state == DRAIN_TO_LOADER);

  // The side giving up the pads must be quiet, not the new one.
  assign old_tx = (state == DRAIN_TO_LOADER) ?
                  core_tx_i : loader_txd_i;

  assign line_idle = (old_tx == IDLE_LEVEL) &&
                     (rx_sync == IDLE_LEVEL);

  assign cnt_clear = (state_next != state);

  uart_idle_detect #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .TO_CYCLES   (TO_CYCLES)
  ) u_idle (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .active    (drain),
    .line_idle (line_idle),
    .done      (idle_done),
    .timeout   (drain_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOADER;
    end else begin
      state <= state_next;
    end
  end

  // Abort is tested first, then idle completion, then timeout.
  always_comb begin
    state_next  = state;
    forced_next = 1'b0;
    unique case (state)
      LOADER: begin
        if (sel_sync) state_next = DRAIN_TO_CORE;
      end
      DRAIN_TO_CORE: begin
        if (!sel_sync) begin
          state_next = LOADER;
        end else if (idle_done) begin
          state_next = CORE;
        end else if (drain_to) begin
          state_next  = CORE;
          forced_next = 1'b1;
        end
      end
      CORE: begin
        if (!sel_sync) state_next = DRAIN_TO_LOADER;
      end
      DRAIN_TO_LOADER: begin
        if (sel_sync) begin
          state_next = CORE;
        end else if (idle_done) begin
          state_next = LOADER;
        end else if (drain_to) begin
          state_next  = LOADER;
          forced_next = 1'b1;
        end
      end
      default: begin
        state_next = LOADER;
      end
    endcase
  end

  // Outputs register the next state so they change with the state.
  assign core_side = (state_next == CORE) ||
                     (state_next == DRAIN_TO_LOADER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_o       <= IDLE_LEVEL;
      loader_rxd_o    <= IDLE_LEVEL;
      core_rx_o       <= IDLE_LEVEL;
      fetch_enable_o  <= 1'b0;
      owner_o         <= 1'b0;
      switching_o     <= 1'b0;
      forced_switch_o <= 1'b0;
    end else begin
      uart_tx_o       <= core_side ? core_tx_i : loader_txd_i;
      loader_rxd_o    <= core_side ? IDLE_LEVEL : rx_sync;
      core_rx_o       <= core_side ? rx_sync : IDLE_LEVEL;
      fetch_enable_o  <= (state_next == CORE);
      owner_o         <= core_side;
      switching_o     <= (state_next == DRAIN_TO_CORE) ||
                         (state_next == DRAIN_TO_LOADER);
      forced_switch_o <= forced_next;
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Scoreboard bench for uart_port_arbiter with a behavioural model.
// Driver pushes expected outputs per edge; monitor compares them.
module tb_uart_port_arbiter;

  localparam int IDLE_CYC = 120;
  localparam int TO_CYC   = 320;

  logic clk = 1'b0;
  logic rst_n;
  logic sel_req_i;
  logic uart_rx_i;
  logic uart_tx_o;
  logic loader_rxd_o;
  logic loader_txd_i;
  logic core_rx_o;
  logic core_tx_i;
  logic fetch_enable_o;
  logic owner_o;
  logic switching_o;
  logic forced_switch_o;

  uart_port_arbiter #(
    .CLK_FREQ_HZ        (1000),
    .BAUD               (100),
    .IDLE_BITS          (12),
    .DRAIN_TIMEOUT_BITS (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sel_req_i       (sel_req_i),
    .uart_rx_i       (uart_rx_i),
    .uart_tx_o       (uart_tx_o),
    .loader_rxd_o    (loader_rxd_o),
    .loader_txd_i    (loader_txd_i),
    .core_rx_o       (core_rx_o),
    .core_tx_i       (core_tx_i),
    .fetch_enable_o  (fetch_enable_o),
    .owner_o         (owner_o),
    .switching_o     (switching_o),
    .forced_switch_o (forced_switch_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_forced = 0;

  logic [6:0] exp_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Model: synchronisers are two-edge delays; a drain tracks the
  // current idle run length and its age in cycles.
  bit m_core, m_drain, m_forced;
  int m_idle, m_age;
  bit sh1, sh2, rh1, rh2;

  task automatic model_reset();
    m_core = 0; m_drain = 0; m_forced = 0;
    m_idle = 0; m_age = 0;
    sh1 = 0; sh2 = 0; rh1 = 1; rh2 = 1;
  endtask

  task automatic model_edge();
    bit s, r, lidle, tx;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(7'b1110000);
      return;
    end
    s = sh2;
    r = rh2;
    m_forced = 0;
    if (!m_drain) begin
      if (s != m_core) begin
        m_drain = 1; m_idle = 0; m_age = 0;
      end
    end else if (s == m_core) begin
      m_drain = 0;
    end else begin
      tx = m_core ? core_tx_i : loader_txd_i;
      lidle = tx & r;
      m_idle = lidle ? m_idle + 1 : 0;
      m_age++;
      if (m_idle >= IDLE_CYC) begin
        m_core = !m_core; m_drain = 0;
      end else if (m_age >= TO_CYC) begin
        m_core = !m_core; m_drain = 0; m_forced = 1;
      end
    end
    exp_q.push_back({
      m_core ? core_tx_i : loader_txd_i,
      m_core ? 1'b1 : r,
      m_core ? r : 1'b1,
      m_core & !m_drain,
      m_core, m_drain, m_forced});
    sh2 = sh1; sh1 = sel_req_i;
    rh2 = rh1; rh1 = uart_rx_i;
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs",
          {25'd0, uart_tx_o, loader_rxd_o, core_rx_o,
           fetch_enable_o, owner_o, switching_o,
           forced_switch_o},
          {25'd0, e});
      if (forced_switch_o) n_forced++;
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_lines();
    uart_rx_i = 1; loader_txd_i = 1; core_tx_i = 1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_owner", owner_o, 0);
    chk("rst_tx", uart_tx_o, 1);
    chk("rst_sw", switching_o, 0);
    chk("rst_fe", fetch_enable_o, 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    int f0, thr;
    logic [9:0] frame;
    rst_n = 0;
    sel_req_i = 0;
    idle_lines();
    model_reset();
    ticks(3);
    rst_n = 1;

    // loader passthrough
    for (int i = 0; i < 20; i++) begin
      loader_txd_i = 1'($urandom);
      core_tx_i = 1'($urandom);
      uart_rx_i = 1'($urandom);
      tick();
    end
    idle_lines();
    ticks(4);

    // handover to core on an idle line
    sel_req_i = 1;
    ticks(3);
    chk("sw_start", switching_o, 1);
    ticks(119);
    chk("owner_pre", owner_o, 0);
    tick();
    chk("owner_core", owner_o, 1);
    chk("fe_core", fetch_enable_o, 1);
    for (int i = 0; i < 20; i++) begin
      core_tx_i = 1'($urandom);
      uart_rx_i = 1'($urandom);
      tick();
    end
    idle_lines();
    sel_req_i = 0;
    ticks(130);
    chk("owner_back", owner_o, 0);

    // byte 0x55 with the switch raised mid-frame
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      loader_txd_i = frame[b];
      if (b == 3) sel_req_i = 1;
      ticks(10);
    end
    loader_txd_i = 1;
    ticks(150);
    chk("owner_frame", owner_o, 1);

    // forced handover on a busy RX line
    sel_req_i = 0;
    ticks(130);
    #1 f0 = n_forced;
    sel_req_i = 1;
    for (int i = 0; i < 340; i++) begin
      if (i % 50 == 49) uart_rx_i = ~uart_rx_i;
      tick();
    end
    uart_rx_i = 1;
    #1;
    chk("forced_cnt", n_forced - f0, 1);
    chk("owner_forced", owner_o, 1);

    // aborted drain back to core
    f0 = n_forced;
    sel_req_i = 0;
    ticks(3);
    chk("fe_drain", fetch_enable_o, 0);
    chk("sw_drain", switching_o, 1);
    ticks($urandom_range(5, 55));
    sel_req_i = 1;
    ticks(5);
    #1;
    chk("owner_abort", owner_o, 1);
    chk("fe_abort", fetch_enable_o, 1);
    chk("no_forced", n_forced - f0, 0);

    // reset in the middle of a drain
    sel_req_i = 0;
    core_tx_i = 0;
    ticks(20);
    pulse_reset();
    idle_lines();
    ticks(5);
    chk("owner_after_rst", owner_o, 0);

    // random soak
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 2))
        0: thr = 0;
        1: thr = 20;
        default: thr = 200;
      endcase
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 249) == 0)
          sel_req_i = ~sel_req_i;
        if (thr == 0) begin
          idle_lines();
        end else begin
          loader_txd_i = ($urandom_range(0, thr - 1) != 0);
          core_tx_i = ($urandom_range(0, thr - 1) != 0);
          uart_rx_i = ($urandom_range(0, thr - 1) != 0);
        end
        tick();
      end
    end
    @(negedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_port_arbiter.md
Name: uart_port_arbiter

Overview:
- Shares the single physical UART pad pair between two requesters: the UART-to-SPI boot loader (owner 0) and the SoC core UART (owner 1).
- Ownership follows the fetch-enable switch. Handover happens only at a frame boundary, after the line has been idle long enough, so no byte is split between owners.
- Gates the core fetch enable so the core runs only while it owns the UART.
- Sits at board top level between the pads, the loader bridge and the SoC.

Parameters:
- CLK_FREQ_HZ, 50000000, core clock frequency.
- BAUD, 115200, line rate. BIT_CYCLES = CLK_FREQ_HZ/BAUD, integer divide.
- IDLE_BITS, 12, number of consecutive idle bit-times required before a handover.
- DRAIN_TIMEOUT_BITS, 256, bit-times after which a drain is forced to complete.

Ports:
- clk, in, 1, core clock.
- rst_n, in, 1, asynchronous active-low reset.
- sel_req_i, in, 1, raw switch. 1 requests core ownership. Asynchronous to clk.
- uart_rx_i, in, 1, pad RX. Asynchronous to clk.
- uart_tx_o, out, 1, pad TX.
- loader_rxd_o, out, 1, RX to the loader bridge.
- loader_txd_i, in, 1, TX from the loader bridge.
- core_rx_o, out, 1, RX to the core UART.
- core_tx_i, in, 1, TX from the core UART.
- fetch_enable_o, out, 1, core fetch enable.
- owner_o, out, 1, current owner: 0 loader, 1 core.
- switching_o, out, 1, high while a drain is in progress.
- forced_switch_o, out, 1, one-cycle pulse when a drain ends by timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, and every flop is in the rst_n domain.
- Synchronisers:
  - sel_req_i and uart_rx_i each pass through a 2-flop synchroniser.
  - Reset values: sel sync flops 0, rx sync flops 1.
- Reset values: state LOADER, owner_o=0, uart_tx_o=1, loader_rxd_o=1, core_rx_o=1, fetch_enable_o=0, switching_o=0, forced_switch_o=0, both counters 0.
- Output registers and latency:
  - All outputs are registered.
  - Pad RX to selected requester: 3 cycles.
  - Requester TX to pad: 1 cycle.
  - The non-selected RX output is held at 1 (line idle).
- Routing by state:
  - LOADER: tx = loader_txd_i, loader_rxd_o = rx_sync, core_rx_o = 1, fetch_enable_o = 0, owner_o = 0.
  - DRAIN_TO_CORE: routing as LOADER, switching_o = 1.
  - CORE: tx = core_tx_i, core_rx_o = rx_sync, loader_rxd_o = 1, fetch_enable_o = 1, owner_o = 1.
  - DRAIN_TO_LOADER: routing as CORE, switching_o = 1, fetch_enable_o = 0.
- Idle counter:
  - Counts only in DRAIN states.
  - Increments when the old owner's TX is 1 and rx_sync is 1; clears to 0 in any cycle where either is 0.
  - Saturates at IDLE_CYCLES = IDLE_BITS*BIT_CYCLES.
  - Cleared on every state entry.
- Timeout counter:
  - Counts every DRAIN cycle regardless of line activity.
  - Limit TO_CYCLES = DRAIN_TIMEOUT_BITS*BIT_CYCLES.
  - Cleared on every state entry.
- Transitions:
  - LOADER -> DRAIN_TO_CORE when sel_sync=1.
  - CORE -> DRAIN_TO_LOADER when sel_sync=0.
  - DRAIN_TO_CORE -> CORE when idle counter reaches IDLE_CYCLES-1 while the line is still idle (handover on the IDLE_CYCLES-th idle cycle).
  - DRAIN_TO_LOADER -> LOADER under the same idle condition.
  - Either DRAIN state -> its destination when the timeout counter reaches TO_CYCLES-1. forced_switch_o pulses 1 cycle on that transition.
  - DRAIN_TO_CORE -> LOADER if sel_sync drops before completion (abort, no pulse).
  - DRAIN_TO_LOADER -> CORE if sel_sync rises before completion (abort, no pulse).
- Simultaneous events:
  - Abort beats completion.
  - Completion by idle beats timeout: forced_switch_o=0 if both occur in the same cycle.
- Reset mid-drain: immediate return to LOADER with all reset values. No partial state survives.
- Widths: counters are $clog2(limit+1) bits. Elaboration fails if BIT_CYCLES < 4.

Decomposition:
- Package uart_arb_pkg:
  - State enum (LOADER, DRAIN_TO_CORE, CORE, DRAIN_TO_LOADER), 2 bits.
  - Function computing BIT_CYCLES and counter widths from the parameters.
  - Idle-level constant (1'b1).
- Sub-module uart_idle_detect: the idle counter plus the timeout counter, with clear, done and timeout outputs.
- The top holds the synchronisers, FSM and output registers.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000, BAUD=100, IDLE_BITS=12, DRAIN_TIMEOUT_BITS=32, giving BIT_CYCLES=10, IDLE_CYCLES=120, TO_CYCLES=320.
1. Reset, then loader_txd_i=0 for 1 cycle -> uart_tx_o=0 exactly 1 cycle later. Throughout: core_rx_o=1, fetch_enable_o=0.
2. sel_req_i 0->1 with line idle -> switching_o=1 after 3 cycles. Handover after 120 more idle cycles: owner_o=1, fetch_enable_o=1. Then core_tx_i toggles appear on uart_tx_o.
3. Loader sends byte 0x55 (start, LSB-first) and sel_req_i rises mid-frame -> every bit of the byte reaches the pad intact. Ownership changes 120 idle cycles after the stop bit; the idle count restarts on each 0 bit.
4. In DRAIN_TO_CORE, hold uart_rx_i toggling every 50 cycles -> switch at cycle 320 of the drain, forced_switch_o high exactly 1 cycle, owner_o=1.
5. In CORE, sel_req_i 1->0 -> fetch_enable_o=0 on entry to DRAIN_TO_LOADER. Raise sel_req_i again within 60 cycles -> returns to CORE, fetch_enable_o=1, forced_switch_o never pulses.
6. rst_n low for 1 cycle during DRAIN_TO_LOADER -> asynchronous reset: owner_o=0, uart_tx_o=1, switching_o=0 immediately, and the FSM resumes in LOADER.
